mips_multicycle: RTL and testbench

MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

---
 rtl/mips_multicycle.sv | 206 ++++++++++++++++++++
 tb/tb_mips_multicycle.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core with a single unified memory port.
// One ALU result per state, with IR/MDR/A/B/ALUOut holding registers between states.
//
// state  | meaning
// FETCH  | read instruction at pc, latch IR, advance pc by 4
// DECODE | read rs/rt into A/B, precompute branch target, dispatch on opcode
// MEMADR | effective address A + signext(imm)
// MEMRD  | load read from ALUOut into MDR
// MEMWB  | write MDR to rt
// MEMWR  | store B to ALUOut
// EXEC   | R-type ALU operation selected by funct
// ALUWB  | write ALUOut to rd
// BRANCH | compare A and B, take branch target on BEQ/BNE condition
// ADDIEX | A + signext(imm)
// ADDIWB | write ALUOut to rt
// JUMP   | pseudo-direct jump
// TRAP   | halted on illegal opcode/funct until reset
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32,
  parameter int          BNE_EN   = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      pc,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  state_t      state, state_n;
  logic [31:0] ir, mdr, a, b, aluout;
  logic [31:0] rf [32];
  logic        rst_done;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext;
  logic [31:0] rd_a, rd_b;
  logic [31:0] alu_res, diff;
  logic        funct_ok, take;
  logic        fsm_req, mem_done;
  logic        rf_we, retire;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];
  assign sext  = {{16{ir[15]}}, ir[15:0]};

  // Register 0 is hardwired to zero on the read side; it is never written.
  assign rd_a = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rd_b = (rt == 5'd0) ? 32'd0 : rf[rt];

  // rst_done keeps the port idle for the first cycle after a reset edge, so an
  // aborted access is always followed by at least one mem_req=0 cycle.
  assign fsm_req   = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign mem_req   = fsm_req & rst_done & ~reset;
  assign mem_we    = mem_req & (state == MEMWR);
  assign mem_done  = mem_req & mem_ready;
  assign mem_addr  = (state == FETCH) ? pc : aluout;
  assign mem_wdata = b;
  assign trap      = (state == TRAP);

  assign diff = a - b;
  assign take = (op == OP_BNE) ? (diff != 32'd0) : (diff == 32'd0);

  // R-type ALU; unknown funct codes flag an illegal instruction.
  always_comb begin
    alu_res  = 32'd0;
    funct_ok = 1'b1;
    case (funct)
      6'b100000: alu_res = a + b;
      6'b100010: alu_res = a - b;
      6'b100100: alu_res = a & b;
      6'b100101: alu_res = a | b;
      6'b101010: alu_res = {31'd0, ($signed(a) < $signed(b))};
      default:   funct_ok = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  // Next-state, register-file write control and retire strobe.
  always_comb begin
    state_n  = state;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = aluout;
    retire   = 1'b0;
    case (state)
      FETCH:  if (mem_done) state_n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_R:         state_n = EXEC;
          OP_BEQ:       state_n = BRANCH;
          OP_BNE:       state_n = (BNE_EN != 0) ? BRANCH : TRAP;
          OP_ADDI:      state_n = ADDIEX;
          OP_J:         state_n = JUMP;
          default:      state_n = TRAP;
        endcase
      end
      MEMADR: state_n = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_done) state_n = MEMWB;
      MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr;
        retire   = 1'b1;
        state_n  = FETCH;
      end
      MEMWR: if (mem_done) begin
        retire  = 1'b1;
        state_n = FETCH;
      end
      EXEC:   state_n = funct_ok ? ALUWB : TRAP;
      ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        retire   = 1'b1;
        state_n  = FETCH;
      end
      BRANCH: begin
        retire  = 1'b1;
        state_n = FETCH;
      end
      ADDIEX: state_n = ADDIWB;
      ADDIWB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_n = FETCH;
      end
      JUMP: begin
        retire  = 1'b1;
        state_n = FETCH;
      end
      TRAP:    state_n = TRAP;
      default: state_n = FETCH;
    endcase
  end

  // Datapath holding registers, pc and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      ir       <= 32'd0;
      mdr      <= 32'd0;
      a        <= 32'd0;
      b        <= 32'd0;
      aluout   <= 32'd0;
      instret  <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (retire) instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
      case (state)
        FETCH: if (mem_done) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        DECODE: begin
          a      <= rd_a;
          b      <= rd_b;
          aluout <= pc + {sext[29:0], 2'b00};
        end
        MEMADR, ADDIEX: aluout <= a + sext;
        MEMRD:  if (mem_done) mdr <= mem_rdata;
        EXEC:   aluout <= alu_res;
        BRANCH: if (take) pc <= aluout;
        JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  // Register file: no reset, so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (!reset && rf_we && (rf_waddr != 5'd0)) rf[rf_waddr] <= rf_wdata;
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: two instances (default parameters, and
// RESET_PC=0x400 with BNE disabled) sharing a bench-owned word memory.
module tb_mips_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset0, reset1;
  logic        mem_req0, mem_we0, mem_ready0, trap0;
  logic        mem_req1, mem_we1, mem_ready1, trap1;
  logic [31:0] mem_addr0, mem_wdata0, mem_rdata0, pc0, instret0;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1, pc1, instret1;

  logic [31:0] mem [512];
  assign mem_rdata0 = mem[mem_addr0[10:2]];
  assign mem_rdata1 = mem[mem_addr1[10:2]];

  mips_multicycle dut0 (
    .clk(clk), .reset(reset0), .mem_req(mem_req0), .mem_we(mem_we0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_ready(mem_ready0),
    .mem_rdata(mem_rdata0), .pc(pc0), .trap(trap0), .instret(instret0)
  );

  mips_multicycle #(.RESET_PC(32'h0000_0400), .BNE_EN(0)) dut1 (
    .clk(clk), .reset(reset1), .mem_req(mem_req1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_ready(mem_ready1),
    .mem_rdata(mem_rdata1), .pc(pc1), .trap(trap1), .instret(instret1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall0, stall1, wcnt0, wcnt1;
  logic [31:0] saddr0, saddr1;
  logic [63:0] exp_wr0 [$];
  logic [63:0] exp_wr1 [$];

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, 5'd0, funct};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_write(input int port, input logic [31:0] addr, input logic [31:0] data);
    logic [63:0] e;
    if (port == 0) begin
      chk("wr0_expected", 32'(exp_wr0.size() != 0), 32'd1);
      if (exp_wr0.size() != 0) begin
        e = exp_wr0.pop_front();
        chk("wr0_addr", addr, e[63:32]);
        chk("wr0_data", data, e[31:0]);
      end
    end else begin
      chk("wr1_expected", 32'(exp_wr1.size() != 0), 32'd1);
      if (exp_wr1.size() != 0) begin
        e = exp_wr1.pop_front();
        chk("wr1_addr", addr, e[63:32]);
        chk("wr1_data", data, e[31:0]);
      end
    end
  endtask

  // One clock: sample 1 ns after the edge, decide mem_ready for the cycle,
  // and apply/score any write that completes at the next edge.
  task automatic tick();
    logic hit;
    @(posedge clk);
    #1;
    cyc++;
    hit = mem_req0 && (mem_addr0 == saddr0);
    mem_ready0 = !(hit && (wcnt0 < stall0));
    if (hit && !mem_ready0) wcnt0++; else wcnt0 = 0;
    if (!mem_req0) chk("we0_idle", 32'(mem_we0), 32'd0);
    if (mem_req0 && mem_we0 && mem_ready0) begin
      mem[mem_addr0[10:2]] = mem_wdata0;
      sb_write(0, mem_addr0, mem_wdata0);
    end
    hit = mem_req1 && (mem_addr1 == saddr1);
    mem_ready1 = !(hit && (wcnt1 < stall1));
    if (hit && !mem_ready1) wcnt1++; else wcnt1 = 0;
    if (!mem_req1) chk("we1_idle", 32'(mem_we1), 32'd0);
    if (mem_req1 && mem_we1 && mem_ready1) begin
      mem[mem_addr1[10:2]] = mem_wdata1;
      sb_write(1, mem_addr1, mem_wdata1);
    end
  endtask

  // Advance to the next completing instruction fetch of dut0 (code lives below 0x80).
  task automatic wait_fetch0(output logic [31:0] a, output int c);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (!found && n < 60) begin
      tick();
      n++;
      found = mem_req0 && !mem_we0 && mem_ready0 && (mem_addr0 < 32'h80);
    end
    chk("fetch0_found", 32'(found), 32'd1);
    a = mem_addr0;
    c = cyc;
  endtask

  initial begin
    logic [31:0] fa, prev_a;
    int fc, c0, prev_c, n;

    reset0 = 1'b1; reset1 = 1'b1;
    mem_ready0 = 1'b0; mem_ready1 = 1'b0;
    stall0 = 0; stall1 = 100; wcnt0 = 0; wcnt1 = 0;
    saddr0 = 32'h80; saddr1 = 32'h1F0;
    for (int i = 0; i < 512; i++) mem[i] = 32'hFC00_0000;

    mem[0]  = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);       // addi $1,$0,5
    mem[1]  = enc_i(6'b001000, 5'd0, 5'd2, 16'hFFFD);    // addi $2,$0,-3
    mem[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'b100000);        // add  $3,$1,$2
    mem[3]  = enc_i(6'b101011, 5'd0, 5'd3, 16'h0080);    // sw   $3,0x80
    mem[4]  = enc_i(6'b000100, 5'd1, 5'd1, 16'hFFFF);    // beq  $1,$1,-1
    mem[5]  = enc_i(6'b100011, 5'd0, 5'd4, 16'h0080);    // lw   $4,0x80
    mem[6]  = enc_i(6'b101011, 5'd0, 5'd4, 16'h0084);    // sw   $4,0x84
    mem[7]  = enc_r(5'd2, 5'd1, 5'd5, 6'b101010);        // slt  $5,$2,$1
    mem[8]  = enc_r(5'd1, 5'd1, 5'd0, 6'b100000);        // add  $0,$1,$1
    mem[9]  = enc_i(6'b101011, 5'd0, 5'd5, 16'h0088);    // sw   $5,0x88
    mem[10] = enc_i(6'b101011, 5'd0, 5'd0, 16'h008C);    // sw   $0,0x8C
    mem[11] = enc_r(5'd2, 5'd1, 5'd6, 6'b100010);        // sub  $6,$2,$1
    mem[12] = enc_r(5'd1, 5'd2, 5'd7, 6'b100101);        // or   $7,$1,$2
    mem[13] = enc_r(5'd1, 5'd2, 5'd8, 6'b101010);        // slt  $8,$1,$2
    mem[14] = enc_r(5'd2, 5'd6, 5'd9, 6'b100100);        // and  $9,$2,$6
    mem[15] = enc_i(6'b101011, 5'd0, 5'd6, 16'h0090);
    mem[16] = enc_i(6'b101011, 5'd0, 5'd7, 16'h0094);
    mem[17] = enc_i(6'b101011, 5'd0, 5'd8, 16'h0098);
    mem[18] = enc_i(6'b101011, 5'd0, 5'd9, 16'h009C);
    mem[19] = {6'b000010, 26'h000001C};                  // j 0x70
    mem[256] = enc_i(6'b001000, 5'd0, 5'd7, 16'h0077);   // addi $7,$0,0x77
    mem[257] = enc_i(6'b101011, 5'd0, 5'd7, 16'h01F0);   // sw   $7,0x1F0
    mem[258] = enc_i(6'b000101, 5'd0, 5'd0, 16'h0001);   // bne  (illegal here)

    exp_wr0.push_back({32'h80, 32'd2});
    exp_wr0.push_back({32'h84, 32'd2});
    exp_wr0.push_back({32'h88, 32'd1});
    exp_wr0.push_back({32'h8C, 32'd0});
    exp_wr0.push_back({32'h90, 32'hFFFF_FFF8});
    exp_wr0.push_back({32'h94, 32'hFFFF_FFFD});
    exp_wr0.push_back({32'h98, 32'd0});
    exp_wr0.push_back({32'h9C, 32'hFFFF_FFF8});

    tick(); tick();
    chk("rst0_pc", pc0, 32'h0);
    chk("rst0_instret", instret0, 32'd0);
    chk("rst0_trap", 32'(trap0), 32'd0);
    chk("rst0_req", 32'(mem_req0), 32'd0);
    chk("rst1_pc", pc1, 32'h400);
    chk("rst1_instret", instret1, 32'd0);
    chk("rst1_req", 32'(mem_req1), 32'd0);

    // Straight-line ADDI/ADDI/ADD/SW: 16 cycles, 4 retired.
    reset0 = 1'b0;
    wait_fetch0(fa, c0);
    chk("first_fetch0", fa, 32'h0);
    for (int i = 0; i < 4; i++) wait_fetch0(fa, fc);
    chk("seq_addr", fa, 32'h10);
    chk("seq_cycles", 32'(fc - c0), 32'd16);
    chk("seq_instret", instret0, 32'd4);

    // BEQ loop back to itself, then BNE swapped in falls through.
    prev_c = fc;
    wait_fetch0(fa, fc);
    chk("beq_target", fa, 32'h10);
    chk("beq_cycles", 32'(fc - prev_c), 32'd3);
    chk("beq_instret", instret0, 32'd5);
    mem[4] = enc_i(6'b000101, 5'd1, 5'd1, 16'hFFFF);     // bne $1,$1,-1
    stall0 = 3;
    prev_c = fc;
    wait_fetch0(fa, fc);
    chk("bne_fall", fa, 32'h14);
    chk("bne_cycles", 32'(fc - prev_c), 32'd3);

    // LW with three wait cycles in MEMRD.
    prev_c = fc;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("lw_req", 32'(mem_req0), 32'd1);
      chk("lw_addr", mem_addr0, 32'h80);
      chk("lw_we", 32'(mem_we0), 32'd0);
    end
    wait_fetch0(fa, fc);
    chk("lw_next", fa, 32'h18);
    chk("lw_cycles", 32'(fc - prev_c), 32'd8);
    stall0 = 0;

    // Run to the jump target, which holds an illegal opcode.
    n = 0;
    prev_a = fa;
    while (fa != 32'h70 && n < 20) begin
      prev_a = fa;
      prev_c = fc;
      wait_fetch0(fa, fc);
      n++;
    end
    chk("jump_src", prev_a, 32'h4C);
    chk("jump_dst", fa, 32'h70);
    chk("jump_cycles", 32'(fc - prev_c), 32'd3);
    chk("pretrap_instret", instret0, 32'd21);
    tick();
    chk("decode_no_trap", 32'(trap0), 32'd0);
    tick();
    chk("trap_set", 32'(trap0), 32'd1);
    chk("trap_pc", pc0, 32'h74);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("trap_req", 32'(mem_req0), 32'd0);
      chk("trap_hold", 32'(trap0), 32'd1);
    end
    chk("trap_instret", instret0, 32'd21);
    chk("trap_pc_frozen", pc0, 32'h74);
    chk("wr0_drained", 32'(exp_wr0.size()), 32'd0);

    // Reset keeps the register file; illegal funct traps without retiring.
    reset0 = 1'b1;
    tick(); tick();
    chk("rst0b_trap", 32'(trap0), 32'd0);
    chk("rst0b_pc", pc0, 32'h0);
    chk("rst0b_instret", instret0, 32'd0);
    mem[0] = enc_i(6'b101011, 5'd0, 5'd1, 16'h00A0);     // sw $1,0xA0
    mem[1] = enc_r(5'd1, 5'd1, 5'd10, 6'b000111);        // illegal funct
    mem[2] = enc_i(6'b001000, 5'd0, 5'd11, 16'd1);
    exp_wr0.push_back({32'hA0, 32'd5});
    reset0 = 1'b0;
    n = 0;
    while (!trap0 && n < 40) begin tick(); n++; end
    chk("funct_trap", 32'(trap0), 32'd1);
    chk("funct_trap_pc", pc0, 32'h08);
    chk("funct_trap_instret", instret0, 32'd1);
    chk("wr0_drained2", 32'(exp_wr0.size()), 32'd0);

    // dut1: reset during a wait-stated SW aborts it; restart from 0x400.
    reset1 = 1'b0;
    n = 0;
    while (!(mem_req1 && mem_we1) && n < 30) begin tick(); n++; end
    chk("sw1_req", 32'(mem_req1 && mem_we1), 32'd1);
    chk("sw1_addr", mem_addr1, 32'h1F0);
    chk("sw1_data", mem_wdata1, 32'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sw1_hold_req", 32'(mem_req1), 32'd1);
      chk("sw1_hold_addr", mem_addr1, 32'h1F0);
    end
    reset1 = 1'b1;
    tick();
    chk("abort_req", 32'(mem_req1), 32'd0);
    chk("abort_pc", pc1, 32'h400);
    chk("abort_instret", instret1, 32'd0);
    chk("abort_trap", 32'(trap1), 32'd0);
    tick();
    stall1 = 0;
    exp_wr1.push_back({32'h1F0, 32'h77});
    reset1 = 1'b0;
    n = 0;
    while (!mem_req1 && n < 10) begin tick(); n++; end
    chk("first_fetch1", mem_addr1, 32'h400);
    chk("first_fetch1_we", 32'(mem_we1), 32'd0);
    n = 0;
    while (!trap1 && n < 40) begin tick(); n++; end
    chk("bne_disabled_trap", 32'(trap1), 32'd1);
    chk("bne_disabled_pc", pc1, 32'h40C);
    chk("dut1_instret", instret1, 32'd2);
    chk("wr1_drained", 32'(exp_wr1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
